// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to NUM_WR_PORTS requesters per cycle onto registered
// register-file write ports with matching wakeups. Optional stall counters: REG_WB_ARB_PERF_EN.
module reg_wb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_WR_PORTS  = 2,
  parameter int NUM_PHYS_REGS = 128,
  parameter int WORD_SIZE     = 64,
  localparam int PREG_BITS    = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [NUM_REQ-1:0]                         req_valid_in,
  input  logic [NUM_REQ-1:0][PREG_BITS-1:0]          req_preg_in,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]          req_data_in,
  output logic [NUM_REQ-1:0]                         req_ready_out,
  output logic [NUM_WR_PORTS-1:0]                    wr_en_out,
  output logic [NUM_WR_PORTS-1:0][PREG_BITS-1:0]     wr_index_out,
  output logic [NUM_WR_PORTS-1:0][WORD_SIZE-1:0]     wr_data_out,
  output logic [NUM_WR_PORTS-1:0]                    wake_valid_out,
  output logic [NUM_WR_PORTS-1:0][PREG_BITS-1:0]     wake_preg_out
`ifdef REG_WB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]                   stall_cnt_out
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                            rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                          grant;
  logic [NUM_WR_PORTS-1:0]                     wr_en_q, wr_en_d;
  logic [NUM_WR_PORTS-1:0][PTR_W-1:0]          port_sel;
  logic [NUM_WR_PORTS-1:0][PREG_BITS-1:0]      wr_index_q, wr_index_d;
  logic [NUM_WR_PORTS-1:0][WORD_SIZE-1:0]      wr_data_q, wr_data_d;

  // Scan from rr_ptr upward with wrap; the n-th valid requester found lands on port n.
  always_comb begin : grant_scan
    logic [PTR_W:0]   pos;
    logic [PTR_W-1:0] idx;
    int               n_grant;
    grant    = '0;
    wr_en_d  = '0;
    port_sel = '0;
    rr_ptr_d = rr_ptr_q;
    n_grant  = 0;
    pos      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      idx = pos[PTR_W-1:0];
      if (!rst_in && req_valid_in[idx] && (n_grant < NUM_WR_PORTS)) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (p == n_grant) begin
            wr_en_d[p]  = 1'b1;
            port_sel[p] = idx;
          end
        end
        rr_ptr_d = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        n_grant  = n_grant + 1;
      end
    end
  end

  // Idle ports keep their last index/data.
  always_comb begin
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en_d[p]) begin
        wr_index_d[p] = req_preg_in[port_sel[p]];
        wr_data_d[p]  = req_data_in[port_sel[p]];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= '0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign req_ready_out  = grant;
  assign wr_en_out      = wr_en_q;
  assign wr_index_out   = wr_index_q;
  assign wr_data_out    = wr_data_q;
  assign wake_valid_out = wr_en_q;
  assign wake_preg_out  = wr_index_q;

`ifdef REG_WB_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] stall_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_in[i] && !grant[i] && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: a queue-based reference model predicts grants, write-port
// contents and (with REG_WB_ARB_PERF_EN) stall counts; monitors compare as outputs appear.
module tb_reg_wb_arbiter;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int PB = 7;
  localparam int WS = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0][PB-1:0]  req_preg = '0;
  logic [NR-1:0][WS-1:0]  req_data = '0;
  logic [NR-1:0]          req_ready;
  logic [NP-1:0]          wr_en;
  logic [NP-1:0][PB-1:0]  wr_index;
  logic [NP-1:0][WS-1:0]  wr_data;
  logic [NP-1:0]          wake_valid;
  logic [NP-1:0][PB-1:0]  wake_preg;
`ifdef REG_WB_ARB_PERF_EN
  logic [NR-1:0][31:0]    stall_cnt;
`endif

  reg_wb_arbiter #(.NUM_REQ(NR), .NUM_WR_PORTS(NP), .NUM_PHYS_REGS(128), .WORD_SIZE(WS)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .req_valid_in(req_valid),
    .req_preg_in(req_preg),
    .req_data_in(req_data),
    .req_ready_out(req_ready),
    .wr_en_out(wr_en),
    .wr_index_out(wr_index),
    .wr_data_out(wr_data),
    .wake_valid_out(wake_valid),
    .wake_preg_out(wake_preg)
`ifdef REG_WB_ARB_PERF_EN
    ,
    .stall_cnt_out(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]          en;
    logic [NP-1:0][PB-1:0]  idx;
    logic [NP-1:0][WS-1:0]  dat;
    logic [NR-1:0][31:0]    stall;
  } exp_t;

  exp_t          wr_q[$];
  logic [NR-1:0] rdy_q[$];
  int            checks = 0;
  int            errors = 0;

  // Requester-side state: an item once offered is held until the model says it transferred.
  bit            pend_v[NR];
  logic [PB-1:0] pend_p[NR];
  logic [WS-1:0] pend_d[NR];

  int            m_rr = 0;
  exp_t          m_out;
  longint        m_stall[NR];

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PB-1:0] fresh_preg(input int self);
    logic [PB-1:0] r;
    bit clash;
    do begin
      r = PB'($urandom_range(0, 127));
      clash = 1'b0;
      for (int j = 0; j < NR; j++)
        if (j != self && pend_v[j] && pend_p[j] == r) clash = 1'b1;
    end while (clash);
    return r;
  endfunction

  task automatic new_item(input int i, input logic [PB-1:0] p, input logic [WS-1:0] d);
    pend_v[i] = 1'b1;
    pend_p[i] = p;
    pend_d[i] = d;
  endtask

  task automatic rand_item(input int i);
    new_item(i, fresh_preg(i), {$urandom, $urandom});
  endtask

  // One cycle: present held items, predict the grant set and what the write ports show next cycle.
  task automatic step(input bit r);
    int            win[$];
    logic [NR-1:0] rdy;
    @(posedge clk);
    #2;
    rst = r;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pend_v[i];
      req_preg[i]  = pend_p[i];
      req_data[i]  = pend_d[i];
    end
    rdy = '0;
    if (r) begin
      m_rr = 0;
      m_out.en = '0;
      m_out.idx = '0;
      m_out.dat = '0;
      for (int i = 0; i < NR; i++) m_stall[i] = 0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (pend_v[i] && win.size() < NP) win.push_back(i);
      end
      m_out.en = '0;
      foreach (win[n]) begin
        rdy[win[n]]  = 1'b1;
        m_out.en[n]  = 1'b1;
        m_out.idx[n] = pend_p[win[n]];
        m_out.dat[n] = pend_d[win[n]];
      end
      if (win.size() > 0) m_rr = (win[win.size()-1] + 1) % NR;
      for (int i = 0; i < NR; i++)
        if (pend_v[i] && !rdy[i] && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
      foreach (win[n]) pend_v[win[n]] = 1'b0;
    end
    for (int i = 0; i < NR; i++) m_out.stall[i] = 32'(m_stall[i]);
    rdy_q.push_back(rdy);
    wr_q.push_back(m_out);
  endtask

  initial begin : ready_monitor
    logic [NR-1:0] e;
    forever begin
      @(negedge clk);
      if (rdy_q.size() > 0) begin
        e = rdy_q.pop_front();
        check_vec("req_ready", 256'(req_ready), 256'(e));
      end
    end
  end

  initial begin : write_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check_vec("wr_en", 256'(wr_en), 256'(e.en));
        check_vec("wake_valid", 256'(wake_valid), 256'(e.en));
        check_vec("wr_index", 256'(wr_index), 256'(e.idx));
        check_vec("wake_preg", 256'(wake_preg), 256'(e.idx));
        check_vec("wr_data", 256'(wr_data), 256'(e.dat));
`ifdef REG_WB_ARB_PERF_EN
        check_vec("stall_cnt", 256'(stall_cnt), 256'(e.stall));
`endif
      end
    end
  end

  task automatic drain();
    for (int c = 0; c < 8; c++) begin
      if (!(pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3])) break;
      step(1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      pend_v[i] = 1'b0;
      pend_p[i] = '0;
      pend_d[i] = '0;
      m_stall[i] = 0;
    end
    m_out.en = '0;
    m_out.idx = '0;
    m_out.dat = '0;
    m_out.stall = '0;

    // Reset with every requester valid, then four saturated cycles.
    for (int i = 0; i < NR; i++) rand_item(i);
    step(1'b1);
    step(1'b1);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NR; i++) if (!pend_v[i]) rand_item(i);
      step(1'b0);
    end
    drain();

    // Lone requester 3.
    new_item(3, 7'd45, 64'hDEAD_BEEF);
    step(1'b0);
    step(1'b0);

    // Wrap-around: grant req2 to move the pointer to 3, then req0 + req3.
    new_item(2, fresh_preg(2), {$urandom, $urandom});
    step(1'b0);
    new_item(0, fresh_preg(0), {$urandom, $urandom});
    new_item(3, fresh_preg(3), {$urandom, $urandom});
    step(1'b0);
    step(1'b0);

    // Reset right after a grant drops the registered write.
    for (int i = 0; i < NR; i++) if (!pend_v[i]) rand_item(i);
    step(1'b0);
    step(1'b1);
    drain();

    // Three requesters contending for two ports.
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++) if (!pend_v[i]) rand_item(i);
      step(1'b0);
    end
    drain();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!pend_v[i] && $urandom_range(0, 99) < 60) rand_item(i);
      step($urandom_range(0, 59) == 0);
    end
    step(1'b0);

    @(posedge clk);
    #3;
    check_vec("scoreboard_drained", 256'(wr_q.size() + rdy_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Writeback arbiter for the physical register file. Several functional-unit writeback requesters share a smaller number of register-file write ports. The block selects up to `NUM_WR_PORTS` requests per cycle in round-robin order and registers the winners onto the write ports. In the same cycle it broadcasts the written physical-register tags to the issue logic as wakeups.

## Interface
Parameters:
- `NUM_REQ`, 4: number of writeback requesters (FUs); must be ≥ `NUM_WR_PORTS`.
- `NUM_WR_PORTS`, 2: number of register-file write ports driven.
- `NUM_PHYS_REGS`, 128: physical register count; `PREG_BITS = $clog2(NUM_PHYS_REGS)`.
- `WORD_SIZE`, 64: data width.

Ports:
- `clk_in`  in  1  single clock; all state updates on posedge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `req_valid_in`  in  [NUM_REQ]  requester i holds a result.
- `req_preg_in`  in  [NUM_REQ][PREG_BITS]  destination physical register per requester.
- `req_data_in`  in  [NUM_REQ][WORD_SIZE]  result data per requester.
- `req_ready_out`  out  [NUM_REQ]  requester i granted this cycle (combinational).
- `wr_en_out`  out  [NUM_WR_PORTS]  write-port enable, registered.
- `wr_index_out`  out  [NUM_WR_PORTS][PREG_BITS]  write-port index, registered.
- `wr_data_out`  out  [NUM_WR_PORTS][WORD_SIZE]  write-port data, registered.
- `wake_valid_out`  out  [NUM_WR_PORTS]  equals `wr_en_out`.
- `wake_preg_out`  out  [NUM_WR_PORTS][PREG_BITS]  equals `wr_index_out`.

## Operation
- Handshake:
  - A transfer occurs on a cycle where `req_valid_in[i] && req_ready_out[i]`.
  - Once valid is asserted, the requester holds valid, preg and data stable until ready.
  - Ready may depend on valid. Valid never depends on ready.
- Grant scan:
  - Scan starts at requester index `rr_ptr` and proceeds upward modulo `NUM_REQ`.
  - The first `NUM_WR_PORTS` valid requesters found are granted.
  - The n-th grant in scan order is assigned to write port n.
  - Ungranted ports are idle (`wr_en_out[n]=0`).
- Pointer update:
  - If ≥1 grant occurs, `rr_ptr` becomes (index of last granted requester + 1) mod `NUM_REQ`.
  - With no grants, `rr_ptr` holds.
  - Guarantee: any continuously valid requester is granted within `ceil(NUM_REQ/NUM_WR_PORTS)` cycles.
- Output register: on each posedge, write port n loads the granted preg/data and sets `wr_en_out[n]=1`, or sets `wr_en_out[n]=0` if the port was not granted. Index/data of idle ports are don't-care but held.
- Duplicate pregs: rename guarantees no two requesters target the same preg in one cycle. The arbiter does not check this, and benches must not generate it.

## Timing
- Reset (`rst_in=1` at posedge) clears:
  - `rr_ptr=0`;
  - all `wr_en_out`, `wr_index_out`, `wr_data_out`, `wake_*` = 0;
  - perf counters = 0 (if compiled in).
- While `rst_in=1`, `req_ready_out` is all 0; no transfer occurs.
- Reset mid-operation: a write registered in the prior cycle is dropped. `wr_en_out` is 0 in the cycle after the reset edge.
- Latency: a transfer in cycle T appears on `wr_*_out`/`wake_*` in cycle T+1. The register file commits it at the T+2 edge.
- Throughput: `NUM_WR_PORTS` writes per cycle sustained; no bubbles between back-to-back grants.
- Wrap-around: the scan wraps from `NUM_REQ-1` to 0 within the same cycle.
- All valid with `NUM_REQ == NUM_WR_PORTS`: all granted every cycle.

## Configuration
- `REG_WB_ARB_PERF_EN` defined:
  - Adds output `stall_cnt_out [NUM_REQ][32]`.
  - Per requester, a saturating counter increments each cycle `req_valid_in[i] && !req_ready_out[i]`.
  - Saturates at `32'hFFFF_FFFF`; cleared by `rst_in`.
- Macro undefined: the port and the counters are absent; all other behaviour is identical.

## Test plan
Defaults: `NUM_REQ=4`, `NUM_WR_PORTS=2`.
- Reset with `req_valid_in=4'b1111` held → `req_ready_out=0`, `wr_en_out=2'b00`. First cycle after deassert: ready=`4'b0011`; next cycle: `wr_en_out=2'b11` with port0 = req0 preg/data, port1 = req1 preg/data.
- All four valid, held for 4 cycles → grants 0/1, 2/3, 0/1, 2/3; each requester is granted exactly twice.
- Only req3 valid (preg 7'd45, data 64'hDEAD_BEEF) → port0 writes index 45, data DEAD_BEEF one cycle later with `wake_preg_out[0]=45`. Port1 idle; `rr_ptr` becomes 0.
- With `rr_ptr=3`, req0 and req3 valid → port0 = req3, port1 = req0 (wrap-around); `rr_ptr` becomes 1.
- Grant in cycle T, `rst_in` asserted at the T+1 edge → `wr_en_out=0` after that edge; the write is never presented.
- With `REG_WB_ARB_PERF_EN`: req0–req2 valid for 10 cycles → `stall_cnt_out` sums equal 10 (one stall per cycle); no counter exceeds 4.
